// File: rtl/motor_ctrl_pkg.sv
// Shared state encoding and default parameter values for the motor duty sequencer.
// Optional sweep mode is enabled with the MOTOR_SWEEP_EN macro.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAMP     = 3'd1,
    HOLD     = 3'd2,
    STOPPING = 3'd3,
    SWEEP    = 3'd4
  } motor_state_t;

  localparam int DEF_STEP_DIV    = 2097152;
  localparam int DEF_DUTY_MAX    = 100;
  localparam int DEF_DUTY_STEP   = 10;
  localparam int DEF_TARGET_INIT = 50;
  localparam int DEF_SWEEP_MIN   = 11;

endpackage

// File: rtl/motor_step_tick.sv
// Ramp prescaler: emits a one-cycle tick every STEP_DIV cycles; clr restarts the period.
module motor_step_tick
  import motor_ctrl_pkg::*;
#(
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic clk,
  input  logic rstp,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/motor_duty_sequencer.sv
// Button-driven target/duty controller with soft ramping and emergency stop.
// Define MOTOR_SWEEP_EN to add the sweep_en port and the SWEEP state.
module motor_duty_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int DUTY_MAX    = DEF_DUTY_MAX,
  parameter int DUTY_STEP   = DEF_DUTY_STEP,
  parameter int TARGET_INIT = DEF_TARGET_INIT
`ifdef MOTOR_SWEEP_EN
  , parameter int SWEEP_MIN = DEF_SWEEP_MIN
`endif
) (
  input  logic       clk,
  input  logic       rstp,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_run,
  input  logic       btn_estop,
`ifdef MOTOR_SWEEP_EN
  input  logic       sweep_en,
`endif
  output logic [7:0] duty,
  output logic [7:0] target,
  output logic [2:0] state,
  output logic       running,
  output logic       at_target
);

  localparam logic [7:0] DMAX   = 8'(DUTY_MAX);
  localparam logic [7:0] DSTEP8 = 8'(DUTY_STEP);
  localparam logic [8:0] DSTEP9 = 9'(DUTY_STEP);
  localparam logic [7:0] TINIT  = 8'(TARGET_INIT);
`ifdef MOTOR_SWEEP_EN
  localparam logic [7:0] SMIN   = 8'(SWEEP_MIN);
  logic sweep_up;
`endif

  motor_state_t state_q, state_nxt;
  logic [7:0]   target_nxt;
  logic [8:0]   up_sum;
  logic         tick;
  logic         step_clr;

  assign up_sum = {1'b0, target} + DSTEP9;

  // Target math is done in 9 bits so the upper clamp never sees a wrapped sum.
  always_comb begin
    target_nxt = target;
    if (!btn_estop && btn_up && !btn_down) begin
      target_nxt = (up_sum > {1'b0, DMAX}) ? DMAX : up_sum[7:0];
    end else if (!btn_estop && btn_down && !btn_up) begin
      target_nxt = (target < DSTEP8) ? 8'd0 : target - DSTEP8;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (btn_estop) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_run) begin
`ifdef MOTOR_SWEEP_EN
            if (sweep_en)            state_nxt = SWEEP;
            else if (target != 8'd0) state_nxt = RAMP;
            else                     state_nxt = HOLD;
`else
            state_nxt = (target != 8'd0) ? RAMP : HOLD;
`endif
          end
        end
        RAMP: begin
          if (btn_run)               state_nxt = STOPPING;
          else if (duty == target)   state_nxt = HOLD;
        end
        HOLD: begin
          if (btn_run)               state_nxt = STOPPING;
          else if (target != duty)   state_nxt = RAMP;
        end
        STOPPING: begin
          if (btn_run)               state_nxt = RAMP;
          else if (duty == 8'd0)     state_nxt = IDLE;
        end
`ifdef MOTOR_SWEEP_EN
        SWEEP: begin
          if (btn_run)               state_nxt = STOPPING;
        end
`endif
        default:                     state_nxt = IDLE;
      endcase
    end
  end

  // Restarting the prescaler on entry makes the first step land STEP_DIV cycles later.
  assign step_clr = (state_nxt != state_q);

  motor_step_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick (
    .clk  (clk),
    .rstp (rstp),
    .clr  (step_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q <= IDLE;
      duty    <= 8'd0;
      target  <= TINIT;
      running <= 1'b0;
`ifdef MOTOR_SWEEP_EN
      sweep_up <= 1'b1;
`endif
    end else begin
      state_q <= state_nxt;
      target  <= target_nxt;
      running <= (state_nxt != IDLE);
      if (btn_estop || (state_nxt == IDLE)) begin
        duty <= 8'd0;
      end else if ((state_nxt == state_q) && tick) begin
        case (state_q)
          RAMP:     duty <= (duty < target) ? duty + 8'd1 : duty - 8'd1;
          STOPPING: duty <= duty - 8'd1;
`ifdef MOTOR_SWEEP_EN
          SWEEP: begin
            if (sweep_up) begin
              if (duty >= DMAX) begin
                sweep_up <= 1'b0;
                duty     <= duty - 8'd1;
              end else begin
                duty     <= duty + 8'd1;
              end
            end else begin
              if (duty <= SMIN) begin
                sweep_up <= 1'b1;
                duty     <= duty + 8'd1;
              end else begin
                duty     <= duty - 8'd1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
`ifdef MOTOR_SWEEP_EN
      if ((state_nxt == SWEEP) && (state_q != SWEEP)) sweep_up <= 1'b1;
`endif
    end
  end

  assign state     = state_q;
  assign at_target = (duty == target);

endmodule
